// File: rtl/result_packer_if.sv
// Handshake bundle for the result packer: result stream in, packed words out.
// The bench drives through master; the packer consumes through slave.
interface result_packer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_valid;
  logic                        flush;
  logic [DATA_WIDTH*LANES-1:0] out_data;
  logic [LANES-1:0]            out_keep;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [COUNT_WIDTH-1:0]      overflow_count;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  out_data, out_keep, out_last, out_valid, overflow_count
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output out_data, out_keep, out_last, out_valid, overflow_count
  );
endinterface

// File: rtl/result_packer.sv
// Packs the multiply-add result stream into LANES-wide words, buffers them in a
// first-word-fall-through FIFO and counts words dropped while the FIFO is full.
//
// state   | meaning
// EMPTY   | no lanes filled, lane index is 0
// PARTIAL | 1..LANES-1 lanes filled, waiting for more data or a flush
module result_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  result_packer_if.slave  bus
);
  localparam int LW = $clog2(LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_WIDTH * LANES;
  localparam int EW = WW + LANES + 1;

  typedef enum logic {EMPTY, PARTIAL} state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [WW-1:0]    word_q, word_d, word_fill;
  logic [LANES-1:0] keep_q, keep_d, keep_fill;
  logic             close;

  // Closed words sit one cycle in this stage before entering the FIFO.
  logic             pend_valid_q;
  logic [EW-1:0]    pend_q;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [COUNT_WIDTH-1:0] ovf_q;
  logic             full, pop, push, drop;
  logic [EW-1:0]    head;

  always_comb begin
    word_fill = word_q;
    keep_fill = keep_q;
    if (bus.in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == LW'(i)) begin
          word_fill[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
          keep_fill[i] = 1'b1;
        end
      end
    end

    close   = 1'b0;
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_fill;
    keep_d  = keep_fill;
    case (state_q)
      EMPTY: begin
        if (bus.in_valid && bus.flush) begin
          close = 1'b1;
        end else if (bus.in_valid) begin
          state_d = PARTIAL;
          lane_d  = lane_q + LW'(1);
        end
      end
      PARTIAL: begin
        if (bus.flush || (bus.in_valid && lane_q == LW'(LANES - 1))) begin
          close = 1'b1;
        end else if (bus.in_valid) begin
          lane_d = lane_q + LW'(1);
        end
      end
      default: state_d = EMPTY;
    endcase

    if (close) begin
      state_d = EMPTY;
      lane_d  = '0;
      word_d  = '0;
      keep_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      lane_q       <= '0;
      word_q       <= '0;
      keep_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      keep_q       <= keep_d;
      pend_valid_q <= close;
      if (close) pend_q <= {bus.flush, keep_fill, word_fill};
    end
  end

  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = pend_valid_q && (!full || pop);
  assign drop = pend_valid_q && !push;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop && ovf_q != '1) ovf_q <= ovf_q + COUNT_WIDTH'(1);
    end
  end

  assign head               = mem_q[rd_q];
  assign bus.out_valid      = (cnt_q != '0);
  assign bus.out_data       = bus.out_valid ? head[WW-1:0] : '0;
  assign bus.out_keep       = bus.out_valid ? head[WW +: LANES] : '0;
  assign bus.out_last       = bus.out_valid ? head[EW-1] : 1'b0;
  assign bus.overflow_count = ovf_q;
endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios plus a randomized
// run against a byte-list reference model of word assembly.
module tb_result_packer;
  localparam int DW = 8;
  localparam int LN = 4;
  localparam int FD = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  result_packer_if #(.DATA_WIDTH(DW), .LANES(LN), .COUNT_WIDTH(CW)) bus ();

  result_packer #(.DATA_WIDTH(DW), .LANES(LN), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] exp_data [$];
  logic [3:0]  exp_keep [$];
  logic        exp_last [$];
  logic [7:0]  cur [$];

  task automatic step(input logic v, input logic [7:0] d, input logic f);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = f;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (i < max && !ok) begin
      if (bus.out_valid) ok = 1'b1;
      else begin
        @(negedge clk);
        i++;
      end
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 0; bus.in_data = 0; bus.flush = 0; bus.out_ready = 0;
    rst = 1'b1;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: got %b want 0", bus.out_keep); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bus.out_last); end
    n_checks++; if (bus.overflow_count !== 32'h0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", bus.overflow_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_word;
    bus.out_ready = 1'b1;
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    step(0, 8'h00, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL word_early: got %b want 0", bus.out_valid); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL word_latency: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'h44332211 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL word_content: got %h/%b/%b want 44332211/1111/0", bus.out_data, bus.out_keep, bus.out_last); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL word_popped: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_partial;
    bit ok;
    bus.out_ready = 1'b1;
    step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(0, 8'h00, 1); step(0, 8'h00, 0);
    wait_valid(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_partial_timeout: got none want word"); end
    n_checks++; if (bus.out_data !== 32'h0000A2A1 || bus.out_keep !== 4'b0011 || bus.out_last !== 1'b1) begin
      n_fail++; $display("FAIL flush_partial: got %h/%b/%b want 0000a2a1/0011/1", bus.out_data, bus.out_keep, bus.out_last); end
    step(1, 8'h51, 0); step(1, 8'h52, 0); step(1, 8'h53, 0); step(1, 8'h54, 0); step(0, 8'h00, 0);
    wait_valid(10, ok);
    n_checks++; if (!ok || bus.out_data !== 32'h54535251 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL after_flush: got %h/%b/%b want 54535251/1111/0", bus.out_data, bus.out_keep, bus.out_last); end
  endtask

  task automatic test_flush_complete;
    bit ok;
    bit seen = 1'b0;
    bus.out_ready = 1'b1;
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0); step(1, 8'h04, 1); step(0, 8'h00, 0);
    wait_valid(10, ok);
    n_checks++; if (!ok || bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1) begin
      n_fail++; $display("FAIL flush_complete: got %h/%b/%b want 04030201/1111/1", bus.out_data, bus.out_keep, bus.out_last); end
    step(0, 8'h00, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single: got %b want 0", bus.out_valid); end
    step(0, 8'h00, 1); step(0, 8'h00, 0);
    repeat (5) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL flush_empty: got word want none"); end
  endtask

  task automatic test_overflow;
    logic [31:0] w;
    bus.out_ready = 1'b0;
    for (int wi = 0; wi < 10; wi++)
      for (int l = 0; l < 4; l++) step(1, 8'(wi*16 + l + 1), 0);
    step(0, 8'h00, 0);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.overflow_count !== 32'd2) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", bus.overflow_count); end
    bus.out_ready = 1'b1;
    for (int wi = 0; wi < 8; wi++) begin
      if (wi > 0) @(negedge clk);
      for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(wi*16 + l + 1);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", wi, bus.out_valid, bus.out_data, w); end
    end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] w;
    bus.out_ready = 1'b0;
    for (int wi = 20; wi < 29; wi++)
      for (int l = 0; l < 4; l++) step(1, 8'(wi*8 + l), 0);
    step(0, 8'h00, 0);
    bus.out_ready = 1'b1;
    for (int wi = 20; wi < 29; wi++) begin
      if (wi > 20) @(negedge clk);
      for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(wi*8 + l);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
        n_fail++; $display("FAIL pushpop_word%0d: got %b/%h want 1/%h", wi, bus.out_valid, bus.out_data, w); end
    end
    n_checks++; if (bus.overflow_count !== 32'd2) begin n_fail++; $display("FAIL pushpop_ovf: got %0d want 2", bus.overflow_count); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 14; i++) step(1, 8'hE0 + 8'(i), 0);
    step(0, 8'h00, 0);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_keep !== 4'h0) begin
      n_fail++; $display("FAIL rst_mid_now: got %b/%b want 0/0000", bus.out_valid, bus.out_keep); end
    n_checks++; if (bus.overflow_count !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ovf: got %0d want 0", bus.overflow_count); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step(1, 8'hC1, 0); step(1, 8'hC2, 0); step(1, 8'hC3, 0); step(1, 8'hC4, 0); step(0, 8'h00, 0);
    wait_valid(10, ok);
    n_checks++; if (!ok || bus.out_data !== 32'hC4C3C2C1 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_new: got %h/%b/%b want c4c3c2c1/1111/0", bus.out_data, bus.out_keep, bus.out_last); end
    repeat (5) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_mid_stale: got extra word want none"); end
  endtask

  task automatic test_random;
    logic        v, f;
    logic [7:0]  d;
    logic [31:0] w;
    logic [3:0]  k;
    int          got = 0;
    int          made = 0;
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); cur.delete();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c < 600) begin
        v = 1'($urandom_range(0, 1));
        f = ($urandom_range(0, 7) == 0);
        d = 8'($urandom);
      end else begin
        v = 1'b0; f = 1'b0; d = 8'h00;
      end
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.flush     = f;
      bus.out_ready = (c >= 600) || ($urandom_range(0, 3) != 0);
      if (v) cur.push_back(d);
      if (cur.size() == LN || (f && cur.size() > 0)) begin
        w = '0;
        for (int i = 0; i < cur.size(); i++) w[i*8 +: 8] = cur[i];
        k = 4'((1 << cur.size()) - 1);
        exp_data.push_back(w); exp_keep.push_back(k); exp_last.push_back(f);
        cur.delete();
        made++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_data.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %h want no word", bus.out_data);
        end else begin
          w = exp_data.pop_front(); k = exp_keep.pop_front(); f = exp_last.pop_front();
          got++;
          if (bus.out_data !== w || bus.out_keep !== k || bus.out_last !== f) begin
            n_fail++; $display("FAIL rand_word%0d: got %h/%b/%b want %h/%b/%b", got, bus.out_data, bus.out_keep, bus.out_last, w, k, f);
          end
        end
      end
    end
    n_checks++; if (exp_data.size() != 0 || made == 0) begin
      n_fail++; $display("FAIL rand_missing: got %0d words want %0d", got, made); end
    n_checks++; if (bus.overflow_count !== 32'h0) begin n_fail++; $display("FAIL rand_ovf: got %0d want 0", bus.overflow_count); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_complete();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
